// File: rtl/lfsr_checker_if.sv
// Sample stream and health-status signals between an LFSR sequence source and lfsr_checker.
// Only the width of the error counter is configurable.
interface lfsr_checker_if #(
  parameter int ERR_W = 16
);
  logic             in_valid;
  logic [7:0]       in_data;
  logic             locked;
  logic             err_pulse;
  logic [ERR_W-1:0] err_count;
  logic             stuck;

  modport master (
    output in_valid, in_data,
    input  locked, err_pulse, err_count, stuck
  );

  modport slave (
    input  in_valid, in_data,
    output locked, err_pulse, err_count, stuck
  );
endinterface

// File: rtl/lfsr_checker.sv
// Receive-side checker for the 8-bit XNOR LFSR stream: locks onto it, then counts mismatches.
// Define LFSR_CHECKER_STUCK_DET_EN to flag and refuse to lock onto the 0xFF lock-up state.
//
// state       | meaning
// ------------+---------------------------------------------------------------
// ST_UNLOCKED | tracking received data, counting consecutive sequence matches
// ST_LOCKED   | free-running model predicts each sample, mismatches counted
module lfsr_checker #(
  parameter int LOCK_COUNT = 4,
  parameter int LOSS_COUNT = 3,
  parameter int ERR_W      = 16
) (
  input  logic          clk,
  input  logic          rst,
  lfsr_checker_if.slave chk
);

  localparam logic [0:0] ST_UNLOCKED = 1'b0;
  localparam logic [0:0] ST_LOCKED   = 1'b1;

  localparam int MATCH_W = (LOCK_COUNT > 1) ? $clog2(LOCK_COUNT + 1) : 1;
  localparam int MISS_W  = (LOSS_COUNT > 1) ? $clog2(LOSS_COUNT + 1) : 1;

  localparam logic [MATCH_W-1:0] LOCK_LAST = MATCH_W'(LOCK_COUNT - 1);
  localparam logic [MISS_W-1:0]  LOSS_LAST = MISS_W'(LOSS_COUNT - 1);

`ifdef LFSR_CHECKER_STUCK_DET_EN
  localparam bit STUCK_DET = 1'b1;
`else
  localparam bit STUCK_DET = 1'b0;
`endif

  function automatic logic [7:0] nxt(input logic [7:0] x);
    return {~(x[0] ^ x[2] ^ x[3] ^ x[4]), x[7:1]};
  endfunction

  logic [0:0]         state;
  logic               have_seed;
  logic [7:0]         prev;
  logic [MATCH_W-1:0] match_cnt;
  logic [MISS_W-1:0]  miss_cnt;
  logic               err_pulse_q;
  logic [ERR_W-1:0]   err_cnt;
  logic               seq_ok;

  // With stuck detection a 0xFF sample never counts towards lock.
  assign seq_ok = (chk.in_data == nxt(prev)) && !(STUCK_DET && (chk.in_data == 8'hFF));

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_UNLOCKED;
      have_seed   <= 1'b0;
      prev        <= 8'h00;
      match_cnt   <= '0;
      miss_cnt    <= '0;
      err_pulse_q <= 1'b0;
      err_cnt     <= '0;
    end else begin
      err_pulse_q <= 1'b0;
      if (chk.in_valid) begin
        case (state)
          ST_UNLOCKED: begin
            if (!have_seed) begin
              prev      <= chk.in_data;
              have_seed <= 1'b1;
            end else if (seq_ok) begin
              if (match_cnt == LOCK_LAST) begin
                state     <= ST_LOCKED;
                prev      <= nxt(chk.in_data);
                match_cnt <= '0;
                miss_cnt  <= '0;
              end else begin
                match_cnt <= match_cnt + MATCH_W'(1);
                prev      <= chk.in_data;
              end
            end else begin
              match_cnt <= '0;
              prev      <= chk.in_data;
            end
          end
          default: begin
            if (chk.in_data == prev) begin
              miss_cnt <= '0;
              prev     <= nxt(prev);
            end else begin
              err_pulse_q <= 1'b1;
              if (err_cnt != '1) err_cnt <= err_cnt + ERR_W'(1);
              if (miss_cnt == LOSS_LAST) begin
                state     <= ST_UNLOCKED;
                match_cnt <= '0;
                miss_cnt  <= '0;
                prev      <= chk.in_data;
                have_seed <= 1'b1;
              end else begin
                // Model keeps running so one corrupted sample costs one error.
                miss_cnt <= miss_cnt + MISS_W'(1);
                prev     <= nxt(prev);
              end
            end
          end
        endcase
      end
    end
  end

  assign chk.locked    = (state == ST_LOCKED);
  assign chk.err_pulse = err_pulse_q;
  assign chk.err_count = err_cnt;

`ifdef LFSR_CHECKER_STUCK_DET_EN
  logic stuck_q;

  always_ff @(posedge clk) begin
    if (rst) stuck_q <= 1'b0;
    else if (chk.in_valid) stuck_q <= (chk.in_data == 8'hFF);
  end

  assign chk.stuck = stuck_q;
`else
  assign chk.stuck = 1'b0;
`endif

endmodule

// File: tb/tb_lfsr_checker.sv
// Table-driven bench for lfsr_checker: default instance plus a narrow-counter instance
// (ERR_W=2, LOSS_COUNT=8) for saturation; expectations queued at drive time.
module tb_lfsr_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b;

  lfsr_checker_if #(.ERR_W(16)) if_a ();
  lfsr_checker_if #(.ERR_W(2))  if_b ();

  lfsr_checker #(.LOCK_COUNT(4), .LOSS_COUNT(3), .ERR_W(16)) dut_a (
    .clk (clk),
    .rst (rst_a),
    .chk (if_a.slave)
  );

  lfsr_checker #(.LOCK_COUNT(4), .LOSS_COUNT(8), .ERR_W(2)) dut_b (
    .clk (clk),
    .rst (rst_b),
    .chk (if_b.slave)
  );

  typedef struct {
    logic        rst;
    logic        valid;
    logic [7:0]  data;
    logic        lk;
    logic        ep;
    logic [15:0] ec;
    logic        st;
  } vec_t;

  typedef struct {
    int          tag;
    logic        lk;
    logic        ep;
    logic [15:0] ec;
    logic        st;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

`ifdef LFSR_CHECKER_STUCK_DET_EN
  localparam bit STUCK_DET = 1'b1;
`else
  localparam bit STUCK_DET = 1'b0;
`endif

  task automatic add(input logic r, input logic v, input logic [7:0] d,
                     input logic lk, input logic ep, input logic [15:0] ec, input logic st);
    vec_t x;
    x.rst = r; x.valid = v; x.data = d; x.lk = lk; x.ep = ep; x.ec = ec; x.st = st;
    vecs.push_back(x);
  endtask

  task automatic check1(input int tag, input string what, input logic [15:0] got,
                        input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %0h, expected %0h", what, tag, got, exp);
    end
  endtask

  task automatic step(input bit which, input int tag, input logic r, input logic v,
                      input logic [7:0] d, input logic lk, input logic ep,
                      input logic [15:0] ec, input logic st);
    exp_t e;
    if (!which) begin
      rst_a = r; if_a.in_valid = v; if_a.in_data = d;
    end else begin
      rst_b = r; if_b.in_valid = v; if_b.in_data = d;
    end
    e.tag = tag; e.lk = lk; e.ep = ep; e.ec = ec; e.st = st;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    if (!which) begin
      check1(e.tag, "a.locked",    {15'd0, if_a.locked},    {15'd0, e.lk});
      check1(e.tag, "a.err_pulse", {15'd0, if_a.err_pulse}, {15'd0, e.ep});
      check1(e.tag, "a.err_count", if_a.err_count,          e.ec);
      check1(e.tag, "a.stuck",     {15'd0, if_a.stuck},     {15'd0, e.st});
    end else begin
      check1(e.tag, "b.locked",    {15'd0, if_b.locked},    {15'd0, e.lk});
      check1(e.tag, "b.err_pulse", {15'd0, if_b.err_pulse}, {15'd0, e.ep});
      check1(e.tag, "b.err_count", {14'd0, if_b.err_count}, e.ec);
      check1(e.tag, "b.stuck",     {15'd0, if_b.stuck},     {15'd0, e.st});
    end
  endtask

  initial begin
    logic [7:0] lock_seq [5];
    lock_seq[0] = 8'h00; lock_seq[1] = 8'h80; lock_seq[2] = 8'hC0;
    lock_seq[3] = 8'hE0; lock_seq[4] = 8'hF0;

    rst_a = 1'b1; if_a.in_valid = 1'b0; if_a.in_data = 8'h00;
    rst_b = 1'b1; if_b.in_valid = 1'b0; if_b.in_data = 8'h00;

    // reset with valid asserted: rst dominates
    add(1, 1, 8'h00, 0, 0, 0, 0);
    add(1, 1, 8'h00, 0, 0, 0, 0);
    // lock from reset: locked after the 5th sample
    for (int i = 0; i < 5; i++) add(0, 1, lock_seq[i], (i == 4), 0, 0, 0);
    // single corrupted sample, model expects 78 then BC
    add(0, 1, 8'h79, 1, 1, 1, 0);
    add(0, 1, 8'hBC, 1, 0, 1, 0);
    // three consecutive misses drop lock
    add(0, 1, 8'h11, 1, 1, 2, 0);
    add(0, 1, 8'h22, 1, 1, 3, 0);
    add(0, 1, 8'h33, 0, 1, 4, 0);
    // relock, count held
    for (int i = 0; i < 5; i++) add(0, 1, lock_seq[i], (i == 4), 0, 4, 0);
    // reset mid-lock
    add(1, 1, 8'h78, 0, 0, 0, 0);
    // lock with two idle cycles after each sample; idle data is FF
    for (int i = 0; i < 5; i++) begin
      add(0, 1, lock_seq[i], (i == 4), 0, 0, 0);
      add(0, 0, 8'hFF,       (i == 4), 0, 0, 0);
      add(0, 0, 8'hFF,       (i == 4), 0, 0, 0);
    end
    add(1, 0, 8'h00, 0, 0, 0, 0);
    // constant FF stream, then one 00
    for (int i = 0; i < 6; i++) begin
      if (STUCK_DET) add(0, 1, 8'hFF, 0, 0, 0, 1);
      else           add(0, 1, 8'hFF, (i >= 4), 0, 0, 0);
    end
    if (STUCK_DET) add(0, 1, 8'h00, 0, 0, 0, 0);
    else           add(0, 1, 8'h00, 1, 1, 1, 0);

    @(posedge clk); #1;
    for (int i = 0; i < vecs.size(); i++)
      step(0, i, vecs[i].rst, vecs[i].valid, vecs[i].data,
           vecs[i].lk, vecs[i].ep, vecs[i].ec, vecs[i].st);
    rst_a = 1'b1;

    // narrow counter: saturation at 3, pulses keep firing, then reset clears all
    step(1, 100, 1, 1, 8'h00, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 101 + i, 0, 1, lock_seq[i], (i == 4), 0, 0, 0);
    step(1, 110, 0, 1, 8'h11, 1, 1, 1, 0);
    step(1, 111, 0, 1, 8'h11, 1, 1, 2, 0);
    step(1, 112, 0, 1, 8'h11, 1, 1, 3, 0);
    step(1, 113, 0, 1, 8'h11, 1, 1, 3, 0);
    step(1, 114, 0, 1, 8'h11, 1, 1, 3, 0);
    step(1, 115, 1, 1, 8'h11, 0, 0, 0, 0);
    step(1, 116, 0, 0, 8'h00, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lfsr_checker.md
# lfsr_checker

- Receive-side checker for the 8-bit XNOR LFSR pseudo-random stream used in the lab designs.
- Consumes one sample per valid cycle and synchronises (locks) to the sequence.
- Once locked, predicts each next value from its own model, and flags and counts mismatches.
- Sits at the consumer end of any generator-driven path, for example a game/LED stimulus path or a loopback test, and gives a pass/fail health indication.

## Interface

- LOCK_COUNT, 4: consecutive correct predictions required to enter LOCKED (≥1).
- LOSS_COUNT, 3: consecutive mismatches in LOCKED that force UNLOCKED (≥1).
- ERR_W, 16: width of the error counter.
- clk  input  1  clock; all logic on posedge.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  in_data is a sample this cycle.
- in_data  input  8  received sequence value.
- locked  output  1  checker synchronised to the sequence.
- err_pulse  output  1  one-cycle pulse per mismatching sample while LOCKED.
- err_count  output  ERR_W  saturating count of mismatches while LOCKED.
- stuck  output  1  last valid sample was the 0xFF lock-up value (see Configuration).

## Operation

- Sequence rule, with nxt(x) = {fb, x[7:1]} and fb = ~(x[0]^x[2]^x[3]^x[4]):
  - 0x00→0x80→0xC0→0xE0→0xF0→0x78→0xBC.
  - 0xFF→0xFF (lock-up state).
- Internal state:
  - FSM {UNLOCKED, LOCKED}.
  - have_seed flag.
  - prev[7:0] holds the last sample (UNLOCKED) or the model value (LOCKED).
  - match_cnt and miss_cnt.
- Cycles with in_valid=0 change nothing; err_pulse=0.
- UNLOCKED, valid sample:
  - have_seed=0: prev<=in_data, have_seed<=1, no comparison.
  - in_data==nxt(prev): match_cnt++. When it reaches LOCK_COUNT, go to LOCKED, set prev<=nxt(in_data), clear miss_cnt.
  - mismatch: match_cnt<=0.
  - In every case other than the lock transition, prev<=in_data (re-seed from received data).
  - err_count is never incremented in UNLOCKED.
- LOCKED, valid sample; the prediction is prev (the model), not the received data:
  - match (in_data==prev): miss_cnt<=0.
  - mismatch: err_pulse<=1, err_count++ (saturating at all-ones), miss_cnt++.
  - If miss_cnt reaches LOSS_COUNT: go to UNLOCKED, match_cnt<=0, prev<=in_data, have_seed<=1.
  - Otherwise prev<=nxt(prev), whether or not the sample matched. A single corrupted sample therefore costs exactly one error.
- err_count is cleared only by rst and holds its value through loss of lock.

## Timing

- All outputs are registered. Each one updates on the clk edge that accepts the sample.
- locked: 1 in the cycle after the LOCK_COUNT-th consecutive match; 0 in the cycle after the LOSS_COUNT-th consecutive miss.
- err_pulse and err_count reflect a sample one cycle after it is accepted. err_pulse never lasts more than one cycle per sample.
- Minimum time to lock from reset: LOCK_COUNT+1 valid samples.
- Reset:
  - rst dominates in_valid.
  - The cycle after rst: locked=0, err_pulse=0, err_count=0, stuck=0, FSM=UNLOCKED, have_seed=0, counters 0.
  - The same applies when rst is asserted mid-lock.
- Counter saturation: once err_count=2^ERR_W−1, it stays there; err_pulse still fires.

## Configuration

- LFSR_CHECKER_STUCK_DET_EN defined:
  - A valid in_data==0xFF sets stuck=1 on the next cycle.
  - The next valid non-0xFF sample clears stuck.
  - In UNLOCKED, a 0xFF sample is treated as a mismatch (match_cnt<=0), so the checker can never lock onto the lock-up state.
- Undefined:
  - stuck is tied to 0.
  - 0xFF is an ordinary value. A constant 0xFF stream is self-consistent and locks after LOCK_COUNT+1 samples.

## Test plan

- Lock from reset: defaults, in_valid=1, in_data 00,80,C0,E0,F0 → locked=1 in the cycle after F0 is accepted; err_count=0, err_pulse never asserted.
- Single error: after the lock above, send 79 (model expects 78), then BC → err_pulse high for exactly one cycle, err_count=1, locked stays 1, no error on BC.
- Loss of lock: after lock, send 3 wrong values (11,22,33) → err_count=3, locked=0 after the third. Then send 00,80,C0,E0,F0 → relocks; err_count stays 3.
- Valid gaps: the lock sequence with 2 idle cycles (in_valid=0, in_data=FF) between samples → identical lock timing counted in samples; no errors; stuck=0.
- Stuck detection: 6 valid FF samples → with LFSR_CHECKER_STUCK_DET_EN, stuck=1 from the cycle after the first, locked=0 throughout. Without the macro, stuck=0 and locked=1 after the 5th.
- Saturation and reset: ERR_W=2, locked, LOSS_COUNT=8, 5 wrong samples → err_count 1,2,3,3,3 with 5 pulses. Then rst for 1 cycle → all outputs 0 the next cycle.
